// File: rtl/x_top_uart_pkg.sv
// Shared types and constants for the UART loopback BIST and its TX/RX engines.
package x_top_uart_pkg;

  // BIST sequencer states
  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait,
    StDone
  } bist_state_e;

  // UART transmitter states
  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

  // UART receiver states
  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  localparam logic [7:0] LfsrSeed = 8'h01;
  // Feedback taps b7, b5, b4, b3
  localparam logic [7:0] LfsrTaps = 8'b1011_1000;

  // One step of the left-shifting Fibonacci LFSR; feedback enters bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LfsrTaps)};
  endfunction

endpackage

// File: rtl/x_top_uart_rx.sv
// 8N1 UART receiver; o_valid pulses for one cycle per byte with a good stop bit.
module x_top_uart_rx
  import x_top_uart_pkg::*;
#(
  parameter int unsigned p_clk_hz = 12000000,
  parameter int unsigned p_baud   = 115200
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data
);

  localparam int unsigned ClksPerBit = p_clk_hz / p_baud;
  localparam logic [15:0] BitLast    = 16'(ClksPerBit - 1);
  localparam logic [15:0] HalfLast   = 16'(ClksPerBit / 2 - 1);

  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        s1_q, s2_q;

  assign o_valid = valid_q;
  assign o_data  = data_q;

  // Next-state: qualify start at mid-bit, then sample each bit one period later
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    valid_d = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (!s2_q) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A glitch shorter than half a bit is not a start bit
          state_d = s2_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RxData: begin
        if (cnt_q == BitLast) begin
          cnt_d  = '0;
          data_d = {s2_q, data_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RxStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RxStop: begin
        if (cnt_q == BitLast) begin
          state_d = RxIdle;
          cnt_d   = '0;
          valid_d = s2_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  // Two-flop synchronizer plus receiver state
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      s1_q    <= i_rx;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/x_top_uart_tx.sv
// 8N1 UART transmitter with a valid/accept byte interface; line idles high.
module x_top_uart_tx
  import x_top_uart_pkg::*;
#(
  parameter int unsigned p_clk_hz = 12000000,
  parameter int unsigned p_baud   = 115200
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_accept,
  output logic       o_tx
);

  localparam int unsigned ClksPerBit = p_clk_hz / p_baud;
  localparam logic [15:0] BitLast    = 16'(ClksPerBit - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        line_q, line_d;

  assign o_accept = i_valid && (state_q == TxIdle);
  assign o_tx     = line_q;

  // Next-state: start bit, eight data bits LSB first, one stop bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    line_d  = line_q;
    unique case (state_q)
      TxIdle: begin
        line_d = 1'b1;
        if (o_accept) begin
          state_d = TxStart;
          cnt_d   = '0;
          shreg_d = i_data;
          line_d  = 1'b0;
        end
      end
      TxStart: begin
        if (cnt_q == BitLast) begin
          state_d = TxData;
          cnt_d   = '0;
          bit_d   = '0;
          line_d  = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      TxData: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = TxStop;
            line_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            line_d  = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      TxStop: begin
        if (cnt_q == BitLast) begin
          state_d = TxIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = TxIdle;
    endcase
  end

  // State register; line held high through reset
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= TxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: rtl/x_top_uart_bist.sv
// UART loopback BIST: sends LFSR bytes, checks each echo, counts mismatches and timeouts.
module x_top_uart_bist
  import x_top_uart_pkg::*;
#(
  parameter int unsigned p_clk_hz      = 12000000,
  parameter int unsigned p_baud        = 115200,
  parameter int unsigned p_num_bytes   = 16,
  parameter int unsigned p_timeout_cyc = 4 * (p_clk_hz / p_baud) * 10
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_start,
  input  logic       i_rx,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_pass,
  output logic       o_fail,
  output logic [7:0] o_err_cnt
);

  localparam logic [31:0] TmoLast  = 32'(p_timeout_cyc - 1);
  localparam logic [15:0] ByteLast = 16'(p_num_bytes - 1);

  bist_state_e state_q, state_d;
  logic [7:0]  err_q, err_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic [7:0]  lfsr_q, lfsr_d;

  logic        tx_valid, tx_accept;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        byte_evt, add_err;

  assign tx_valid = (state_q == StSend);

  x_top_uart_tx #(
    .p_clk_hz (p_clk_hz),
    .p_baud   (p_baud)
  ) u_tx (
    .i_clk    (i_clk),
    .i_nrst   (i_nrst),
    .i_valid  (tx_valid),
    .i_data   (lfsr_q),
    .o_accept (tx_accept),
    .o_tx     (o_tx)
  );

  x_top_uart_rx #(
    .p_clk_hz (p_clk_hz),
    .p_baud   (p_baud)
  ) u_rx (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_rx    (i_rx),
    .o_valid (rx_valid),
    .o_data  (rx_data)
  );

  // Sequencer next-state: send a byte, wait for echo or timeout, repeat
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;
    lfsr_d     = lfsr_q;
    byte_evt   = 1'b0;
    add_err    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          state_d    = StSend;
          err_d      = '0;
          byte_cnt_d = '0;
          tmo_d      = '0;
          lfsr_d     = LfsrSeed;
        end
      end
      StSend: begin
        if (tx_accept) begin
          state_d = StWait;
          tmo_d   = '0;
        end
      end
      StWait: begin
        // An echo on the expiry cycle wins over the timeout
        if (rx_valid) begin
          byte_evt = 1'b1;
          add_err  = (rx_data != lfsr_q);
        end else if (tmo_q == TmoLast) begin
          byte_evt = 1'b1;
          add_err  = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
        if (add_err && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
        if (byte_evt) begin
          lfsr_d     = lfsr_next(lfsr_q);
          byte_cnt_d = byte_cnt_q + 16'd1;
          tmo_d      = '0;
          state_d    = (byte_cnt_q == ByteLast) ? StDone : StSend;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q    <= StIdle;
      err_q      <= '0;
      byte_cnt_q <= '0;
      tmo_q      <= '0;
      lfsr_q     <= LfsrSeed;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_q      <= tmo_d;
      lfsr_q     <= lfsr_d;
    end
  end

  // Status outputs decoded from registered state
  always_comb begin
    o_busy    = (state_q == StSend) || (state_q == StWait);
    o_pass    = (state_q == StDone) && (err_q == 8'd0);
    o_fail    = (state_q == StDone) && (err_q != 8'd0);
    o_err_cnt = err_q;
  end

endmodule

// File: doc/x_top_uart_bist.md
X_TOP_UART_BIST -- requirements
Module: x_top_uart_bist

Interface
REQ-001 SHALL have parameter p_clk_hz, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter p_baud, default 115200, UART line rate.
REQ-003 SHALL have parameter p_num_bytes, default 16, bytes per test run; legal range 1..65535.
REQ-004 SHALL have parameter p_timeout_cyc, default 4*(p_clk_hz/p_baud)*10, the echo wait limit in clocks.
REQ-005 SHALL have port i_clk, input, 1, the single clock. Reset is asynchronous and active-low.
REQ-006 SHALL have port i_nrst, input, 1, the asynchronous active-low reset.
REQ-007 SHALL have port i_start, input, 1, a single-cycle run request.
REQ-008 SHALL have port i_rx, input, 1, the UART receive line (echo from device under test).
REQ-009 SHALL have port o_tx, output, 1, the UART transmit line to the device under test (idle high).
REQ-010 SHALL have port o_busy, output, 1, high while a run is in progress.
REQ-011 SHALL have port o_pass, output, 1, high in DONE when the error count is 0.
REQ-012 SHALL have port o_fail, output, 1, high in DONE when the error count is nonzero.
REQ-013 SHALL have port o_err_cnt, output, 8, the saturating error count of the current or last run.

Function
REQ-014 SHALL instantiate x_top_uart_tx and x_top_uart_rx with p_clk_hz and p_baud passed through unchanged, using the valid/accept handshake on TX and the o_valid pulse on RX.
REQ-015 SHALL generate bytes from an 8-bit Fibonacci LFSR: shift left, feedback = b7^b5^b4^b3, seed 8'h01 on each run start.
REQ-016 SHALL implement states IDLE, SEND, WAIT and DONE, transitioning as follows:
- IDLE/DONE -> SEND on i_start; on entry to SEND, clear err_cnt, byte_cnt and the timeout counter, and load the LFSR seed.
- SEND: assert tx valid with data = LFSR value; on tx accept -> WAIT, and tx valid drops in the same cycle as accept.
- WAIT: timeout counter increments every cycle.
  - On rx valid: compare rx data with the LFSR value; on mismatch, err_cnt += 1.
  - If the timeout counter reaches p_timeout_cyc-1 without rx valid: err_cnt += 1.
  - On either event: advance the LFSR, byte_cnt += 1, clear the timeout counter; -> DONE if byte_cnt == p_num_bytes-1, else -> SEND.
- DONE: hold o_pass/o_fail and o_err_cnt until the next i_start.
REQ-017 SHALL saturate err_cnt at 8'hFF.
REQ-018 SHALL ignore i_start while in SEND or WAIT.
REQ-019 SHALL ignore rx valid outside WAIT; such stray bytes SHALL NOT be counted as errors.
REQ-020 SHALL, when rx valid and timeout expiry fall in the same cycle, treat the byte as received (compare only, no timeout error).
REQ-021 SHALL drive o_busy = 1 in SEND and WAIT, and 0 otherwise.
REQ-022 SHALL drive o_pass/o_fail = 0 outside DONE; o_err_cnt is registered and updates the cycle after the event.

Reset
REQ-023 SHALL asynchronously return to IDLE on i_nrst low, including mid-frame.
REQ-024 SHALL reset o_busy=0, o_pass=0, o_fail=0, o_err_cnt=0, byte_cnt=0, timeout=0, LFSR=8'h01, and tx valid=0.
REQ-025 SHALL hold o_tx high during reset and after release until the next SEND.

Structure
REQ-026 SHALL place the state enum, LFSR seed and tap mask in shared package x_top_uart_pkg.
REQ-027 SHALL keep the LFSR in-line; the only sub-modules are the existing x_top_uart_tx and x_top_uart_rx.

Verification
REQ-028 SHALL cover loopback o_tx->i_rx with p_num_bytes=4 and one i_start pulse -> frames 0x01,0x02,0x04,0x08 on o_tx; o_pass=1, o_err_cnt=0.
REQ-029 SHALL cover i_rx tied high with p_num_bytes=4 -> four timeouts; o_err_cnt=4, o_fail=1, o_busy falls after about 4 frames plus 4 timeouts.
REQ-030 SHALL cover a bench echo model inverting the 3rd byte (0x04->0xFB) -> o_err_cnt=1, o_fail=1.
REQ-031 SHALL cover i_start re-pulsed mid-WAIT -> ignored and the run completes normally; then i_nrst low mid-frame -> all outputs 0, o_tx=1, and a new run passes.
REQ-032 SHALL cover p_num_bytes=300 with an echo model returning 0x00 -> o_err_cnt saturates at 0xFF, o_fail=1.
REQ-033 SHALL cover an echo arriving on exactly the timeout-expiry cycle -> no timeout error is counted.
